ddr_axi_arbiter: RTL and testbench
==================================

# ddr_axi_arbiter

Shares the single DDR AXI4 port between two AXI4 masters: index 0 is the cache path (ext_mem) and index 1 is the VersatCNN DMA. It sits between the system core's two AXI master bundles and the memory controller. The read and write channels are arbitrated independently, each burst-locked, with round-robin fairness. One transaction per channel is outstanding on the DDR side at any time.

## Interface
Parameters:
- ADDR_W, default `DDR_ADDR_W: AXI address width.
- DATA_W, default `MIG_BUS_W: AXI data width. Strobe width is DATA_W/8.
- ID_W, default 1: AXI ID width. IDs pass through unchanged.

Ports. Slave-side buses are packed, with master i in slice [i*W +: W]:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  in  2*{ID_W,ADDR_W,8,3,2,1,4,3,4,1}  write-address request from each master.
- s_axi_awready  out  2  write-address accept, per master.
- s_axi_w{data,strb,last,valid}  in  2*{DATA_W,DATA_W/8,1,1}  write data from each master.
- s_axi_wready  out  2  write-data accept, per master.
- s_axi_b{resp,valid}  out  2*{2,1}  write response to each master.
- s_axi_bready  in  2  write-response accept from each master.
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}  in  2*{...}  read-address request, same widths as AW.
- s_axi_arready  out  2  read-address accept, per master.
- s_axi_r{data,resp,last,valid}  out  2*{DATA_W,2,1,1}  read data to each master.
- s_axi_rready  in  2  read-data accept from each master.
- m_axi_* (AW, W, B, AR, R)  mirrors one slave slice  the single DDR-side AXI4 master port.

## Operation
- The read and write arbiters are separate. They may serve different masters, or the same master, concurrently.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any s_axi_arvalid is set, register rgnt. With both requesting, rgnt = rprio; otherwise rgnt is the sole requester. Then go to R_ADDR.
  - R_ADDR: forward AR of rgnt to m_axi_ar*. On m_axi_arvalid & m_axi_arready, go to R_DATA.
  - R_DATA: route m_axi_r* to slice rgnt and s_axi_rready[rgnt] to m_axi_rready. On the beat where rvalid & rready & rlast, go to R_IDLE and set rprio = ~rgnt.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: grant selection is identical to the read side, using wgnt and wprio on awvalid.
  - W_ADDR: forward AW. On the AW handshake, go to W_DATA.
  - W_DATA: forward W of wgnt. On the W handshake with wlast, go to W_RESP.
  - W_RESP: route B to wgnt. On bvalid & bready, go to W_IDLE and set wprio = ~wgnt.
- Write data is gated until W_DATA. s_axi_wready stays 0 even if a master presents W before its AW is accepted; the master holds the beat.
- Non-granted slices, and all slices outside the relevant state, are held at zero: awready, wready, bvalid, arready and rvalid are 0.
- m_axi_*valid is 0 outside its forwarding state. m_axi_rready and m_axi_bready are 0 outside R_DATA and W_RESP respectively.
- Response codes (rresp, bresp) are forwarded unmodified. SLVERR and DECERR do not alter sequencing.
- Payload fields (addr, len, data and the rest) are muxed by the registered grant. They may be don't-care while the matching valid is 0.

## Timing
- Reset values:
  - Both FSMs are IDLE; rgnt = wgnt = 0; rprio = wprio = 0.
  - All m_axi_*valid, m_axi_rready, m_axi_bready, s_axi_*ready, s_axi_rvalid and s_axi_bvalid are 0.
- Grant latency: a request seen in IDLE at cycle t produces m_axi_arvalid (or m_axi_awvalid) at t+1.
- Handshake paths: ready, valid and data paths through the arbiter are combinational once granted. There is zero added latency per R or W beat.
- Inter-burst bubble: the arbiter spends exactly one IDLE cycle between consecutive bursts on a channel. The completion cycle goes to IDLE; the next grant is registered on the following edge.
- Simultaneous request and completion: a new request arriving in the same cycle as rlast (or the B handshake) is evaluated in the next IDLE cycle against the updated prio.
- Back-pressure: if s_axi_rready[rgnt] = 0, m_axi_rready = 0 and the beat is held. The FSM does not advance.
- len = 0: a single-beat burst. rlast or wlast on the first beat completes the burst.
- Reset asserted mid-burst: on the next edge all FSMs return to IDLE and all outputs take their reset values. The DDR controller shares rst, so no burst is drained.

## Test plan
- **Single read:** s0 arvalid with arlen = 3, addr = 0x100 -> m_axi_arvalid 1 cycle later with addr 0x100. Four R beats reach slice 0 with rlast on the 4th. s_axi_rvalid[1] stays 0 throughout.
- **Contention:** both arvalid at the first cycle after reset, each with len = 1 -> master 0 is served first. Master 1's m_axi_arvalid rises exactly 2 cycles after master 0's rlast handshake. A third simultaneous round then grants master 0 again, alternating.
- **Concurrency:** s0 read (len = 7) and s1 write (len = 3) start together -> both proceed in parallel. The B response is routed only to slice 1. R data goes only to slice 0.
- **Early W:** s1 wvalid asserted 3 cycles before awvalid, with m_axi_awready delayed 2 cycles -> s_axi_wready[1] = 0 until the cycle after the AW handshake. The data then passes unchanged with the correct strb.
- **Back-pressure:** during a granted read, drop s_axi_rready[0] for 4 cycles -> m_axi_rready = 0 for those 4 cycles. No beat is lost or duplicated, and the beat count matches arlen + 1.
- **Reset mid-burst:** assert rst during beat 2 of an 8-beat write -> the next cycle has all valids and readies at 0. After release, a request from s1 alone is granted at t+1.

Source files
------------

// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter: shares one DDR AXI4 port between cache and DMA.
// Read and write channels arbitrate independently, burst-locked, round-robin.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif
`ifndef MIG_BUS_W
`define MIG_BUS_W 32
`endif

module ddr_axi_arbiter #(
  parameter int ADDR_W = `DDR_ADDR_W,
  parameter int DATA_W = `MIG_BUS_W,
  parameter int ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // slave-side write address
  input  logic [2*ID_W-1:0]       s_axi_awid,
  input  logic [2*ADDR_W-1:0]     s_axi_awaddr,
  input  logic [15:0]             s_axi_awlen,
  input  logic [5:0]              s_axi_awsize,
  input  logic [3:0]              s_axi_awburst,
  input  logic [1:0]              s_axi_awlock,
  input  logic [7:0]              s_axi_awcache,
  input  logic [5:0]              s_axi_awprot,
  input  logic [7:0]              s_axi_awqos,
  input  logic [1:0]              s_axi_awvalid,
  output logic [1:0]              s_axi_awready,
  // slave-side write data
  input  logic [2*DATA_W-1:0]     s_axi_wdata,
  input  logic [2*(DATA_W/8)-1:0] s_axi_wstrb,
  input  logic [1:0]              s_axi_wlast,
  input  logic [1:0]              s_axi_wvalid,
  output logic [1:0]              s_axi_wready,
  // slave-side write response
  output logic [3:0]              s_axi_bresp,
  output logic [1:0]              s_axi_bvalid,
  input  logic [1:0]              s_axi_bready,
  // slave-side read address
  input  logic [2*ID_W-1:0]       s_axi_arid,
  input  logic [2*ADDR_W-1:0]     s_axi_araddr,
  input  logic [15:0]             s_axi_arlen,
  input  logic [5:0]              s_axi_arsize,
  input  logic [3:0]              s_axi_arburst,
  input  logic [1:0]              s_axi_arlock,
  input  logic [7:0]              s_axi_arcache,
  input  logic [5:0]              s_axi_arprot,
  input  logic [7:0]              s_axi_arqos,
  input  logic [1:0]              s_axi_arvalid,
  output logic [1:0]              s_axi_arready,
  // slave-side read data
  output logic [2*DATA_W-1:0]     s_axi_rdata,
  output logic [3:0]              s_axi_rresp,
  output logic [1:0]              s_axi_rlast,
  output logic [1:0]              s_axi_rvalid,
  input  logic [1:0]              s_axi_rready,
  // DDR-side write address
  output logic [ID_W-1:0]         m_axi_awid,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // DDR-side write data
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // DDR-side write response
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // DDR-side read address
  output logic [ID_W-1:0]         m_axi_arid,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // DDR-side read data
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_t;

  r_state_t r_st, r_nxt;
  w_state_t w_st, w_nxt;
  logic     rgnt, rgnt_nxt, rprio, rprio_nxt;
  logic     wgnt, wgnt_nxt, wprio, wprio_nxt;
  int       ri, wi;

  assign ri = int'(rgnt);
  assign wi = int'(wgnt);

  assign m_axi_arid    = s_axi_arid[ri*ID_W +: ID_W];
  assign m_axi_araddr  = s_axi_araddr[ri*ADDR_W +: ADDR_W];
  assign m_axi_arlen   = s_axi_arlen[ri*8 +: 8];
  assign m_axi_arsize  = s_axi_arsize[ri*3 +: 3];
  assign m_axi_arburst = s_axi_arburst[ri*2 +: 2];
  assign m_axi_arlock  = s_axi_arlock[ri];
  assign m_axi_arcache = s_axi_arcache[ri*4 +: 4];
  assign m_axi_arprot  = s_axi_arprot[ri*3 +: 3];
  assign m_axi_arqos   = s_axi_arqos[ri*4 +: 4];

  assign m_axi_awid    = s_axi_awid[wi*ID_W +: ID_W];
  assign m_axi_awaddr  = s_axi_awaddr[wi*ADDR_W +: ADDR_W];
  assign m_axi_awlen   = s_axi_awlen[wi*8 +: 8];
  assign m_axi_awsize  = s_axi_awsize[wi*3 +: 3];
  assign m_axi_awburst = s_axi_awburst[wi*2 +: 2];
  assign m_axi_awlock  = s_axi_awlock[wi];
  assign m_axi_awcache = s_axi_awcache[wi*4 +: 4];
  assign m_axi_awprot  = s_axi_awprot[wi*3 +: 3];
  assign m_axi_awqos   = s_axi_awqos[wi*4 +: 4];

  assign m_axi_wdata = s_axi_wdata[wi*DATA_W +: DATA_W];
  assign m_axi_wstrb = s_axi_wstrb[wi*SW +: SW];
  assign m_axi_wlast = s_axi_wlast[wi];

  assign s_axi_rdata = {2{m_axi_rdata}};
  assign s_axi_rresp = {2{m_axi_rresp}};
  assign s_axi_rlast = {2{m_axi_rlast}};
  assign s_axi_bresp = {2{m_axi_bresp}};

  // read channel: grant, address forward, then burst data routing
  always_comb begin
    r_nxt         = r_st;
    rgnt_nxt      = rgnt;
    rprio_nxt     = rprio;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_arready = 2'b00;
    s_axi_rvalid  = 2'b00;
    unique case (r_st)
      R_IDLE: begin
        if (|s_axi_arvalid) begin
          rgnt_nxt = (&s_axi_arvalid) ? rprio : s_axi_arvalid[1];
          r_nxt    = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axi_arvalid       = s_axi_arvalid[rgnt];
        s_axi_arready[rgnt] = m_axi_arready;
        if (s_axi_arvalid[rgnt] && m_axi_arready)
          r_nxt = R_DATA;
      end
      R_DATA: begin
        m_axi_rready       = s_axi_rready[rgnt];
        s_axi_rvalid[rgnt] = m_axi_rvalid;
        if (m_axi_rvalid && s_axi_rready[rgnt] && m_axi_rlast) begin
          r_nxt     = R_IDLE;
          rprio_nxt = ~rgnt;
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  // read channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= R_IDLE;
      rgnt  <= 1'b0;
      rprio <= 1'b0;
    end else begin
      r_st  <= r_nxt;
      rgnt  <= rgnt_nxt;
      rprio <= rprio_nxt;
    end
  end

  // write channel: grant, address, gated data, then response routing
  always_comb begin
    w_nxt         = w_st;
    wgnt_nxt      = wgnt;
    wprio_nxt     = wprio;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_axi_awready = 2'b00;
    s_axi_wready  = 2'b00;
    s_axi_bvalid  = 2'b00;
    unique case (w_st)
      W_IDLE: begin
        if (|s_axi_awvalid) begin
          wgnt_nxt = (&s_axi_awvalid) ? wprio : s_axi_awvalid[1];
          w_nxt    = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axi_awvalid       = s_axi_awvalid[wgnt];
        s_axi_awready[wgnt] = m_axi_awready;
        if (s_axi_awvalid[wgnt] && m_axi_awready)
          w_nxt = W_DATA;
      end
      W_DATA: begin
        m_axi_wvalid       = s_axi_wvalid[wgnt];
        s_axi_wready[wgnt] = m_axi_wready;
        if (s_axi_wvalid[wgnt] && m_axi_wready && s_axi_wlast[wgnt])
          w_nxt = W_RESP;
      end
      W_RESP: begin
        m_axi_bready       = s_axi_bready[wgnt];
        s_axi_bvalid[wgnt] = m_axi_bvalid;
        if (m_axi_bvalid && s_axi_bready[wgnt]) begin
          w_nxt     = W_IDLE;
          wprio_nxt = ~wgnt;
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  // write channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      w_st  <= W_IDLE;
      wgnt  <= 1'b0;
      wprio <= 1'b0;
    end else begin
      w_st  <= w_nxt;
      wgnt  <= wgnt_nxt;
      wprio <= wprio_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// tb_ddr_axi_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level channel-ownership model.
module tb_ddr_axi_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic [2*IW-1:0] s_axi_awid, s_axi_arid;
  logic [2*AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [15:0]     s_axi_awlen, s_axi_arlen;
  logic [5:0]      s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [3:0]      s_axi_awburst, s_axi_arburst;
  logic [1:0]      s_axi_awlock, s_axi_arlock;
  logic [7:0]      s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
  logic [1:0]      s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [2*DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [2*SW-1:0] s_axi_wstrb;
  logic [1:0]      s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]      s_axi_bresp, s_axi_rresp;
  logic [1:0]      s_axi_bvalid, s_axi_bready;
  logic [1:0]      s_axi_rlast, s_axi_rvalid, s_axi_rready;

  logic [IW-1:0]   m_axi_awid, m_axi_arid;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [7:0]      m_axi_awlen, m_axi_arlen;
  logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]      m_axi_awburst, m_axi_arburst;
  logic            m_axi_awlock, m_axi_arlock;
  logic [3:0]      m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  ddr_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awlock = '0;
    s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
    s_axi_awvalid = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '0;
    s_axi_wvalid = '0; s_axi_bready = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = '0;
    s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr();
    step();
    step();
    rst = 1'b0;
  endtask

  // Channel-ownership model: who owns each channel and how far it got.
  int r_own = -1;
  bit r_adone = 1'b0;
  int r_last = 1;
  int w_own = -1;
  int w_ph = 0;
  int w_last = 1;

  always @(negedge clk) begin : mdl
    logic       e_arv, e_rrdy, e_awv, e_wv, e_brdy;
    logic [1:0] e_arrdy, e_rv, e_awrdy, e_wrdy, e_bv;
    int         o;
    if (mon_on) begin
      e_arv = 0; e_rrdy = 0; e_awv = 0; e_wv = 0; e_brdy = 0;
      e_arrdy = 0; e_rv = 0; e_awrdy = 0; e_wrdy = 0; e_bv = 0;
      if (r_own >= 0) begin
        o = r_own;
        if (!r_adone) begin
          e_arv = s_axi_arvalid[o];
          e_arrdy[o] = m_axi_arready;
          if (e_arv) begin
            chk("araddr", m_axi_araddr, s_axi_araddr[o*AW +: AW]);
            chk("arlen", m_axi_arlen, s_axi_arlen[o*8 +: 8]);
            chk("arid", m_axi_arid, s_axi_arid[o*IW +: IW]);
          end
        end else begin
          e_rv[o] = m_axi_rvalid;
          e_rrdy = s_axi_rready[o];
          if (m_axi_rvalid) begin
            chk("rdata", s_axi_rdata[o*DW +: DW], m_axi_rdata);
            chk("rresp", s_axi_rresp[o*2 +: 2], m_axi_rresp);
            chk("rlast", s_axi_rlast[o], m_axi_rlast);
          end
        end
      end
      if (w_own >= 0) begin
        o = w_own;
        if (w_ph == 0) begin
          e_awv = s_axi_awvalid[o];
          e_awrdy[o] = m_axi_awready;
          if (e_awv) begin
            chk("awaddr", m_axi_awaddr, s_axi_awaddr[o*AW +: AW]);
            chk("awlen", m_axi_awlen, s_axi_awlen[o*8 +: 8]);
          end
        end else if (w_ph == 1) begin
          e_wv = s_axi_wvalid[o];
          e_wrdy[o] = m_axi_wready;
          if (e_wv) begin
            chk("wdata", m_axi_wdata, s_axi_wdata[o*DW +: DW]);
            chk("wstrb", m_axi_wstrb, s_axi_wstrb[o*SW +: SW]);
            chk("wlast", m_axi_wlast, s_axi_wlast[o]);
          end
        end else begin
          e_bv[o] = m_axi_bvalid;
          e_brdy = s_axi_bready[o];
          if (m_axi_bvalid)
            chk("bresp", s_axi_bresp[o*2 +: 2], m_axi_bresp);
        end
      end
      chk("m_arvalid", m_axi_arvalid, e_arv);
      chk("s_arready", s_axi_arready, e_arrdy);
      chk("s_rvalid", s_axi_rvalid, e_rv);
      chk("m_rready", m_axi_rready, e_rrdy);
      chk("m_awvalid", m_axi_awvalid, e_awv);
      chk("s_awready", s_axi_awready, e_awrdy);
      chk("m_wvalid", m_axi_wvalid, e_wv);
      chk("s_wready", s_axi_wready, e_wrdy);
      chk("s_bvalid", s_axi_bvalid, e_bv);
      chk("m_bready", m_axi_bready, e_brdy);
      if (rst) begin
        r_own = -1; r_adone = 0; r_last = 1;
        w_own = -1; w_ph = 0; w_last = 1;
      end else begin
        if (r_own < 0) begin
          if (s_axi_arvalid != 0) begin
            r_own = (s_axi_arvalid == 2'b11) ? 1 - r_last :
                    (s_axi_arvalid[0] ? 0 : 1);
            r_adone = 0;
          end
        end else if (!r_adone) begin
          if (s_axi_arvalid[r_own] && m_axi_arready) r_adone = 1;
        end else if (m_axi_rvalid && s_axi_rready[r_own] && m_axi_rlast) begin
          r_last = r_own;
          r_own = -1;
        end
        if (w_own < 0) begin
          if (s_axi_awvalid != 0) begin
            w_own = (s_axi_awvalid == 2'b11) ? 1 - w_last :
                    (s_axi_awvalid[0] ? 0 : 1);
            w_ph = 0;
          end
        end else if (w_ph == 0) begin
          if (s_axi_awvalid[w_own] && m_axi_awready) w_ph = 1;
        end else if (w_ph == 1) begin
          if (s_axi_wvalid[w_own] && m_axi_wready && s_axi_wlast[w_own])
            w_ph = 2;
        end else if (m_axi_bvalid && s_axi_bready[w_own]) begin
          w_last = w_own;
          w_own = -1;
        end
      end
    end
  end

  task automatic rand_cycle;
    rst = ($urandom_range(299) == 0);
    s_axi_awid = 2'($urandom); s_axi_arid = 2'($urandom);
    s_axi_awaddr = {$urandom, $urandom};
    s_axi_araddr = {$urandom, $urandom};
    s_axi_awlen = 16'($urandom); s_axi_arlen = 16'($urandom);
    s_axi_awsize = 6'($urandom); s_axi_arsize = 6'($urandom);
    s_axi_awburst = 4'($urandom); s_axi_arburst = 4'($urandom);
    s_axi_awvalid = 2'($urandom); s_axi_arvalid = 2'($urandom);
    s_axi_wdata = {$urandom, $urandom};
    s_axi_wstrb = 8'($urandom);
    s_axi_wlast = 2'($urandom); s_axi_wvalid = 2'($urandom);
    s_axi_bready = 2'($urandom); s_axi_rready = 2'($urandom);
    m_axi_awready = ($urandom_range(3) != 0);
    m_axi_wready = ($urandom_range(3) != 0);
    m_axi_arready = ($urandom_range(3) != 0);
    m_axi_bvalid = 1'($urandom); m_axi_bresp = 2'($urandom);
    m_axi_rvalid = ($urandom_range(3) != 0);
    m_axi_rlast = ($urandom_range(3) == 0);
    m_axi_rdata = $urandom; m_axi_rresp = 2'($urandom);
  endtask

  initial begin : main
    int beats;
    int left [2];
    bit infl [2];
    int gid [$];
    int gcyc [$];
    int dcyc [$];
    int bt;
    clr();
    rst = 1'b1;
    step();
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                        m_axi_bready, m_axi_rready}, 0);
    chk("rst_s_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    chk("rst_s_valid", {s_axi_bvalid, s_axi_rvalid}, 0);
    step();
    rst = 1'b0;

    // single read with back-pressure on beat 1
    s_axi_arvalid = 2'b01;
    s_axi_araddr[31:0] = 32'h100;
    s_axi_arlen[7:0] = 8'd3;
    m_axi_arready = 1'b1;
    @(negedge clk);
    chk("rd_t0_arvalid", m_axi_arvalid, 0);
    step();
    @(negedge clk);
    chk("rd_t1_arvalid", m_axi_arvalid, 1);
    chk("rd_t1_addr", m_axi_araddr, 32'h100);
    chk("rd_t1_len", m_axi_arlen, 3);
    step();
    s_axi_arvalid = 2'b00;
    m_axi_rvalid = 1'b1;
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      m_axi_rdata = 32'hD000 + b;
      m_axi_rlast = (b == 3);
      if (b == 1) begin
        s_axi_rready = 2'b00;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_rready", m_axi_rready, 0);
          step();
        end
      end
      s_axi_rready = 2'b11;
      @(negedge clk);
      chk("rd_rvalid", s_axi_rvalid, 2'b01);
      chk("rd_data", s_axi_rdata[31:0], 32'hD000 + b);
      if (s_axi_rvalid[0] && m_axi_rready) beats++;
      step();
    end
    chk("rd_beats", beats, 4);
    clr();
    @(negedge clk);
    chk("rd_done_rvalid", s_axi_rvalid, 0);

    // contention: alternating grants, one bubble between bursts
    do_reset();
    left[0] = 2; left[1] = 2;
    infl[0] = 0; infl[1] = 0;
    bt = 0;
    s_axi_araddr = {32'h300, 32'h200};
    s_axi_arlen = {8'd1, 8'd1};
    s_axi_arid = 2'b10;
    m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b1;
    s_axi_rready = 2'b11;
    for (int c = 0; c < 80 && dcyc.size() < 4; c++) begin
      for (int i = 0; i < 2; i++)
        s_axi_arvalid[i] = (left[i] > 0) && !infl[i];
      m_axi_rlast = (bt == 1);
      m_axi_rdata = c;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (s_axi_arvalid[i] && s_axi_arready[i]) begin
          infl[i] = 1;
          left[i]--;
        end
      if (m_axi_arvalid && m_axi_arready) begin
        gid.push_back(int'(m_axi_arid));
        gcyc.push_back(c);
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (m_axi_rlast) begin
          bt = 0;
          dcyc.push_back(c);
          for (int i = 0; i < 2; i++)
            if (s_axi_rvalid[i]) infl[i] = 0;
        end else bt++;
      end
      step();
    end
    chk("cont_bursts", dcyc.size(), 4);
    if (dcyc.size() == 4 && gid.size() == 4) begin
      chk("cont_g0", gid[0], 0);
      chk("cont_g1", gid[1], 1);
      chk("cont_g2", gid[2], 0);
      chk("cont_g3", gid[3], 1);
      chk("cont_first", gcyc[0], 1);
      chk("cont_gap", gcyc[1], dcyc[0] + 2);
    end
    clr();

    // early W: data gated until AW handshake completes
    do_reset();
    s_axi_wvalid = 2'b10;
    s_axi_wdata = {32'hCAFE0001, 32'h0};
    s_axi_wstrb = 8'b0110_0000;
    s_axi_wlast = 2'b10;
    s_axi_awaddr = {32'h440, 32'h0};
    s_axi_awid = 2'b10;
    m_axi_wready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) s_axi_awvalid = 2'b10;
      if (c == 6) m_axi_awready = 1'b1;
      @(negedge clk);
      chk("ew_wready_low", s_axi_wready, 0);
      if (c == 4) chk("ew_awvalid", m_axi_awvalid, 1);
      step();
    end
    s_axi_awvalid = 2'b00;
    m_axi_awready = 1'b0;
    @(negedge clk);
    chk("ew_wready", s_axi_wready, 2'b10);
    chk("ew_wdata", m_axi_wdata, 32'hCAFE0001);
    chk("ew_wstrb", m_axi_wstrb, 4'b0110);
    step();
    s_axi_wvalid = 2'b00;
    m_axi_bvalid = 1'b1;
    m_axi_bresp = 2'd2;
    s_axi_bready = 2'b10;
    @(negedge clk);
    chk("ew_bvalid", s_axi_bvalid, 2'b10);
    chk("ew_bresp", s_axi_bresp[3:2], 2'd2);
    step();
    clr();

    // reset in the middle of an 8-beat write
    do_reset();
    s_axi_awvalid = 2'b01;
    s_axi_awaddr = {32'h900, 32'h800};
    s_axi_awlen = {8'd0, 8'd7};
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    s_axi_wvalid = 2'b01;
    step();
    step();
    s_axi_awvalid = 2'b00;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rmb_beat2", s_axi_wready, 2'b01);
    step();
    rst = 1'b0;
    s_axi_awvalid = 2'b10;
    @(negedge clk);
    chk("rmb_m_zero", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 0);
    chk("rmb_s_zero", {s_axi_awready, s_axi_wready, s_axi_arready,
                       s_axi_bvalid, s_axi_rvalid}, 0);
    step();
    s_axi_wvalid = 2'b00;
    @(negedge clk);
    chk("rmb_s1_awvalid", m_axi_awvalid, 1);
    chk("rmb_s1_addr", m_axi_awaddr, 32'h900);
    step();
    clr();

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rand_cycle();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
